// File: rtl/mac_tx_frame_scheduler_if.sv
// ---------------------------------------------------------------------------
// mac_tx_frame_scheduler_if
//
// Purpose : groups the request/descriptor inputs and the generator-facing
//           outputs of mac_tx_frame_scheduler into one bundle.
//
// Signals : i_req            per-source frame request (level)
//           i_dest_address   packed per-source destination MAC (48 b each)
//           i_eth_type       packed per-source EtherType (16 b each)
//           i_payload_length packed per-source payload length (16 b each)
//           i_src_address    global source MAC
//           i_gen_done       end-of-frame pulse from the MAC generator
//           o_gen_start      start pulse to the MAC generator
//           o_dest_address / o_src_address / o_eth_type / o_payload_length
//                            latched descriptor of the granted source
//           o_sel            index of the granted source (payload mux steer)
//           o_grant          one-hot grant, held until WAIT_DONE exits
//           o_ack            one-hot descriptor-consumed pulse
//           o_len_err        granted descriptor had an illegal length
//           o_timeout        generator did not report done in time
//           o_busy           scheduler not idle
//           o_frame_cnt      (SCHED_STATS_EN only) per-source frame counters
//           o_err_cnt        (SCHED_STATS_EN only) error counter
//
// Modports: slave  - the scheduler
//           master - whoever drives requests and the generator done pulse
//
// Optional macro: SCHED_STATS_EN adds the statistics outputs.
// ---------------------------------------------------------------------------
interface mac_tx_frame_scheduler_if #(
    parameter int NUM_REQ = 4
) ();
    localparam int SEL_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    i_req;
    logic [NUM_REQ*48-1:0] i_dest_address;
    logic [NUM_REQ*16-1:0] i_eth_type;
    logic [NUM_REQ*16-1:0] i_payload_length;
    logic [47:0]           i_src_address;
    logic                  i_gen_done;

    logic                  o_gen_start;
    logic [47:0]           o_dest_address;
    logic [47:0]           o_src_address;
    logic [15:0]           o_eth_type;
    logic [15:0]           o_payload_length;
    logic [SEL_W-1:0]      o_sel;
    logic [NUM_REQ-1:0]    o_grant;
    logic [NUM_REQ-1:0]    o_ack;
    logic                  o_len_err;
    logic                  o_timeout;
    logic                  o_busy;
`ifdef SCHED_STATS_EN
    logic [NUM_REQ*32-1:0] o_frame_cnt;
    logic [15:0]           o_err_cnt;
`endif

    modport slave (
        input  i_req, i_dest_address, i_eth_type, i_payload_length,
               i_src_address, i_gen_done,
        output o_gen_start, o_dest_address, o_src_address, o_eth_type,
               o_payload_length, o_sel, o_grant, o_ack, o_len_err,
               o_timeout, o_busy
`ifdef SCHED_STATS_EN
        , output o_frame_cnt, o_err_cnt
`endif
    );

    modport master (
        output i_req, i_dest_address, i_eth_type, i_payload_length,
               i_src_address, i_gen_done,
        input  o_gen_start, o_dest_address, o_src_address, o_eth_type,
               o_payload_length, o_sel, o_grant, o_ack, o_len_err,
               o_timeout, o_busy
`ifdef SCHED_STATS_EN
        , input o_frame_cnt, o_err_cnt
`endif
    );
endinterface

// File: rtl/mac_tx_frame_scheduler.sv
// ---------------------------------------------------------------------------
// mac_tx_frame_scheduler
//
// Purpose : round-robin scheduler that shares one MAC/MII frame generator
//           among NUM_REQ sources. The winning descriptor is latched, the
//           generator is started, the scheduler waits for done (or a
//           timeout) and then holds an inter-frame gap before re-arbitrating.
//
// Ports   : clk      single clock
//           i_rst_n  synchronous active-low reset
//           bus      mac_tx_frame_scheduler_if.slave (requests, descriptors,
//                    generator handshake, status pulses)
//
// Optional macro: SCHED_STATS_EN adds saturating per-source frame counters
//           (o_frame_cnt) and an error counter (o_err_cnt).
// ---------------------------------------------------------------------------
module mac_tx_frame_scheduler #(
    parameter int NUM_REQ          = 4,
    parameter int PAYLOAD_MAX_SIZE = 64,
    parameter int IFG_CYCLES       = 12,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                       clk,
    input  logic                       i_rst_n,
    mac_tx_frame_scheduler_if.slave    bus
);
    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam int IFG_W = $clog2(IFG_CYCLES + 1);

    localparam logic [15:0]        LEN_MAX  = 16'(PAYLOAD_MAX_SIZE);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IFG_W-1:0]   IFG_LAST = IFG_W'(IFG_CYCLES - 1);
    localparam logic [SEL_W-1:0]   SEL_LAST = SEL_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_IFG
    } state_t;

    // Per-source views of the packed descriptor buses.
    logic [47:0] dest_arr [NUM_REQ];
    logic [15:0] type_arr [NUM_REQ];
    logic [15:0] len_arr  [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign dest_arr[gi] = bus.i_dest_address[48*gi +: 48];
        assign type_arr[gi] = bus.i_eth_type[16*gi +: 16];
        assign len_arr[gi]  = bus.i_payload_length[16*gi +: 16];
    end

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               gen_start_q, gen_start_d;
    logic               len_err_q, len_err_d;
    logic               timeout_q, timeout_d;
    logic               busy_q, busy_d;
    logic [47:0]        dest_q, dest_d;
    logic [47:0]        src_q, src_d;
    logic [15:0]        type_q, type_d;
    logic [15:0]        len_q, len_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [IFG_W-1:0]   ifg_cnt_q, ifg_cnt_d;
`ifdef SCHED_STATS_EN
    logic [31:0]        frame_cnt_q [NUM_REQ];
    logic [31:0]        frame_cnt_d [NUM_REQ];
    logic [15:0]        err_cnt_q, err_cnt_d;
`endif

    // Round-robin pick: scanning from the highest offset down to zero means
    // the last hit is the first requester at or after the pointer.
    logic [SEL_W-1:0] win_idx;
    logic             win_found;
    logic             win_len_ok;

    always_comb begin : arb_comb
        int cand;
        cand    = 0;
        win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (bus.i_req[cand]) begin
                win_idx = SEL_W'(cand);
            end
        end
    end

    assign win_found  = |bus.i_req;
    assign win_len_ok = (len_arr[win_idx] != 16'd0) && (len_arr[win_idx] <= LEN_MAX);

    always_comb begin : next_comb
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        dest_d      = dest_q;
        src_d       = src_q;
        type_d      = type_q;
        len_d       = len_q;
        tmo_cnt_d   = tmo_cnt_q;
        ifg_cnt_d   = ifg_cnt_q;
        // Status outputs are single-cycle pulses.
        ack_d       = '0;
        gen_start_d = 1'b0;
        len_err_d   = 1'b0;
        timeout_d   = 1'b0;
`ifdef SCHED_STATS_EN
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                // Length is checked here so the start/len_err pulse is
                // already registered in the START cycle (one-cycle latency).
                if (win_found) begin
                    sel_d       = win_idx;
                    grant_d     = ONE_HOT0 << win_idx;
                    ack_d       = ONE_HOT0 << win_idx;
                    dest_d      = dest_arr[win_idx];
                    type_d      = type_arr[win_idx];
                    len_d       = len_arr[win_idx];
                    src_d       = bus.i_src_address;
                    ptr_d       = (win_idx == SEL_LAST) ? '0 : win_idx + 1'b1;
                    gen_start_d = win_len_ok;
                    len_err_d   = ~win_len_ok;
                    busy_d      = 1'b1;
                    state_d     = S_START;
                end
            end

            S_START: begin
                if (len_err_q) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    tmo_cnt_d = '0;
                    state_d   = S_WAIT_DONE;
                end
            end

            S_WAIT_DONE: begin
                // Done is tested first so it wins over a coinciding expiry.
                if (bus.i_gen_done) begin
                    grant_d   = '0;
                    ifg_cnt_d = '0;
                    state_d   = S_IFG;
`ifdef SCHED_STATS_EN
                    if (frame_cnt_q[sel_q] != '1) begin
                        frame_cnt_d[sel_q] = frame_cnt_q[sel_q] + 32'd1;
                    end
`endif
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    ifg_cnt_d = '0;
                    state_d   = S_IFG;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            S_IFG: begin
                if (ifg_cnt_q == IFG_LAST) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef SCHED_STATS_EN
        if ((len_err_d || timeout_d) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            grant_q     <= '0;
            ack_q       <= '0;
            gen_start_q <= 1'b0;
            len_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            dest_q      <= '0;
            src_q       <= '0;
            type_q      <= '0;
            len_q       <= '0;
            tmo_cnt_q   <= '0;
            ifg_cnt_q   <= '0;
`ifdef SCHED_STATS_EN
            for (int k = 0; k < NUM_REQ; k++) begin
                frame_cnt_q[k] <= '0;
            end
            err_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            gen_start_q <= gen_start_d;
            len_err_q   <= len_err_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            dest_q      <= dest_d;
            src_q       <= src_d;
            type_q      <= type_d;
            len_q       <= len_d;
            tmo_cnt_q   <= tmo_cnt_d;
            ifg_cnt_q   <= ifg_cnt_d;
`ifdef SCHED_STATS_EN
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    assign bus.o_gen_start      = gen_start_q;
    assign bus.o_dest_address   = dest_q;
    assign bus.o_src_address    = src_q;
    assign bus.o_eth_type       = type_q;
    assign bus.o_payload_length = len_q;
    assign bus.o_sel            = sel_q;
    assign bus.o_grant          = grant_q;
    assign bus.o_ack            = ack_q;
    assign bus.o_len_err        = len_err_q;
    assign bus.o_timeout        = timeout_q;
    assign bus.o_busy           = busy_q;

`ifdef SCHED_STATS_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pack_stats
        assign bus.o_frame_cnt[32*gi +: 32] = frame_cnt_q[gi];
    end
    assign bus.o_err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_mac_tx_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mac_tx_frame_scheduler
//
// Directed and randomized checks of mac_tx_frame_scheduler. Two instances:
// u_dut (TIMEOUT_CYCLES=1024) for the main scenarios and u_dut_to
// (TIMEOUT_CYCLES=16) for the timeout scenarios. Expected values come from
// a transaction-level model: round-robin pick by modular arithmetic over the
// request mask, length legality, and frame timing derived from the state
// durations (START 1, WAIT_DONE until done, IFG_CYCLES, IDLE 1).
// ---------------------------------------------------------------------------
module tb_mac_tx_frame_scheduler;
    localparam int NR   = 4;
    localparam int PMAX = 64;
    localparam int IFG  = 12;
    localparam int TMO  = 16;

    logic clk;
    logic rst_n;
    logic rst_t_n;
    int   cyc;
    int   n_checks;
    int   n_errs;
    int   mptr;

    mac_tx_frame_scheduler_if #(.NUM_REQ(NR)) bus ();
    mac_tx_frame_scheduler_if #(.NUM_REQ(NR)) bus_t ();

    mac_tx_frame_scheduler #(
        .NUM_REQ(NR), .PAYLOAD_MAX_SIZE(PMAX), .IFG_CYCLES(IFG), .TIMEOUT_CYCLES(1024)
    ) u_dut (
        .clk(clk), .i_rst_n(rst_n), .bus(bus)
    );

    mac_tx_frame_scheduler #(
        .NUM_REQ(NR), .PAYLOAD_MAX_SIZE(PMAX), .IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TMO)
    ) u_dut_to (
        .clk(clk), .i_rst_n(rst_t_n), .bus(bus_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First requester at or after ptr, wrapping.
    function automatic int rr_pick(input logic [NR-1:0] mask, input int ptr);
        for (int i = 0; i < NR; i++) begin
            if (mask[(ptr + i) % NR]) return (ptr + i) % NR;
        end
        return -1;
    endfunction

    task automatic set_desc(input int k, input logic [47:0] d, input logic [15:0] t,
                            input logic [15:0] l);
        bus.i_dest_address[48*k +: 48]   = d;
        bus.i_eth_type[16*k +: 16]       = t;
        bus.i_payload_length[16*k +: 16] = l;
    endtask

    // Called right after the tick on which o_gen_start was seen (cycle S):
    // drives i_gen_done during cycle S+d, returns after the edge sampling it.
    task automatic do_done(input int d);
        for (int j = 0; j < d; j++) tick();
        bus.i_gen_done = 1'b1;
        tick();
        bus.i_gen_done = 1'b0;
    endtask

    // Counts cycles until o_busy drops (bounded).
    task automatic measure_idle(input string tag, input int exp);
        int n;
        n = 0;
        while (bus.o_busy && n < IFG + 10) begin
            tick();
            n++;
        end
        check(tag, n, exp);
    endtask

    // Waits for the next o_ack (bounded); returns the cycles waited.
    task automatic wait_ack(output int n);
        n = 0;
        while (bus.o_ack == '0 && n < IFG + 40) begin
            tick();
            n++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, bus.o_gen_start, 0);
        check({tag, "_ack"},   bus.o_ack, 0);
        check({tag, "_grant"}, bus.o_grant, 0);
        check({tag, "_sel"},   bus.o_sel, 0);
        check({tag, "_busy"},  bus.o_busy, 0);
        check({tag, "_lerr"},  bus.o_len_err, 0);
        check({tag, "_tmo"},   bus.o_timeout, 0);
        check({tag, "_dest"},  bus.o_dest_address, 0);
        check({tag, "_src"},   bus.o_src_address, 0);
        check({tag, "_type"},  bus.o_eth_type, 0);
        check({tag, "_len"},   bus.o_payload_length, 0);
    endtask

    initial begin
        int w, n, prev, d;
        logic [NR-1:0] mask;
        logic [47:0]   rsrc;
        logic [15:0]   rlen;
        logic          legal;

        cyc = 0; n_checks = 0; n_errs = 0; mptr = 0;
        rst_n = 1'b0; rst_t_n = 1'b0;
        bus.i_req = '0; bus.i_dest_address = '0; bus.i_eth_type = '0;
        bus.i_payload_length = '0; bus.i_src_address = '0; bus.i_gen_done = 1'b0;
        bus_t.i_req = '0; bus_t.i_dest_address = '0; bus_t.i_eth_type = '0;
        bus_t.i_payload_length = '0; bus_t.i_src_address = '0; bus_t.i_gen_done = 1'b0;

        // ---------------- reset state
        tick(); tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1; rst_t_n = 1'b1;
        tick();

        // ---------------- single request
        set_desc(0, 48'hFFFF_FFFF_FFFF, 16'h0800, 16'd8);
        bus.i_src_address = 48'h1234_5678_9ABC;
        bus.i_req = 4'b0001;
        tick();
        check("single_start", bus.o_gen_start, 1);
        check("single_ack",   bus.o_ack, 4'b0001);
        check("single_grant", bus.o_grant, 4'b0001);
        check("single_sel",   bus.o_sel, 0);
        check("single_dest",  bus.o_dest_address, 48'hFFFF_FFFF_FFFF);
        check("single_type",  bus.o_eth_type, 16'h0800);
        check("single_len",   bus.o_payload_length, 8);
        check("single_src",   bus.o_src_address, 48'h1234_5678_9ABC);
        check("single_lerr",  bus.o_len_err, 0);
        mptr = 1;
        bus.i_req = '0;
        do_done(20);
        check("single_grant_clr", bus.o_grant, 0);
        measure_idle("single_idle_gap", IFG);
        $display("txn single: src=0 len=8 done@+20");

        // ---------------- fairness: order 0,1,2,3,0,1
        rst_n = 1'b0; tick(); rst_n = 1'b1; mptr = 0;
        for (int k = 0; k < NR; k++) set_desc(k, 48'h0A0000000000 + 48'(k), 16'h0800, 16'(10 + k));
        bus.i_req = 4'b1111;
        tick();
        prev = 0;
        for (int f = 0; f < 6; f++) begin
            if (f > 0) begin
                wait_ack(n);
                // START + 5 WAIT_DONE cycles (done in the 5th) + IFG + 1 IDLE
                check("fair_spacing", cyc - prev, 5 + 2 + IFG);
            end
            w = rr_pick(4'b1111, mptr);
            check("fair_start", bus.o_gen_start, 1);
            check("fair_sel", bus.o_sel, w);
            check("fair_len", bus.o_payload_length, 10 + w);
            mptr = (w + 1) % NR;
            prev = cyc;
            $display("txn fair %0d: src=%0d", f, w);
            if (f == 5) bus.i_req = '0;
            do_done(5);
        end
        measure_idle("fair_idle_gap", IFG);

        // ---------------- length check on source 2
        set_desc(2, 48'h0200_0000_0002, 16'h86DD, 16'd0);
        bus.i_req = 4'b0100;
        tick();
        check("len0_err", bus.o_len_err, 1);
        check("len0_start", bus.o_gen_start, 0);
        check("len0_ack", bus.o_ack, 4'b0100);
        mptr = 3;
        set_desc(2, 48'h0200_0000_0002, 16'h86DD, 16'd65);
        tick();
        check("len0_grant_clr", bus.o_grant, 0);
        check("len0_busy_clr", bus.o_busy, 0);
        tick();
        check("len65_err", bus.o_len_err, 1);
        check("len65_start", bus.o_gen_start, 0);
        set_desc(2, 48'h0200_0000_0002, 16'h86DD, 16'd64);
        tick();
        tick();
        check("len64_err", bus.o_len_err, 0);
        check("len64_start", bus.o_gen_start, 1);
        check("len64_len", bus.o_payload_length, 64);
        bus.i_req = '0;
        do_done(1);
        measure_idle("len64_idle_gap", IFG);
        $display("txn lencheck: src=2 lengths 0,65,64");

        // ---------------- reset mid-frame
        bus.i_req = 4'b0100;
        tick();
        check("rstmid_pre_sel", bus.o_sel, 2);
        bus.i_req = '0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        check_all_zero("rstmid");
        rst_n = 1'b1; mptr = 0;
        bus.i_req = 4'b1010;
        tick();
        w = rr_pick(4'b1010, mptr);
        check("rstmid_sel", bus.o_sel, w);
        check("rstmid_ack", bus.o_ack, 64'(1) << w);
        mptr = (w + 1) % NR;
        bus.i_req = '0;
        do_done(2);
        measure_idle("rstmid_idle_gap", IFG);
        $display("txn rstmid: src=%0d after reset", w);

        // ---------------- timeout (instance with TIMEOUT_CYCLES=16)
        bus_t.i_payload_length[15:0] = 16'd8;
        bus_t.i_req = 4'b0001;
        tick();
        check("tmo_start", bus_t.o_gen_start, 1);
        bus_t.i_req = '0;
        for (int j = 0; j < TMO; j++) tick();
        check("tmo_not_yet", bus_t.o_timeout, 0);
        tick();
        check("tmo_pulse", bus_t.o_timeout, 1);
        check("tmo_grant_clr", bus_t.o_grant, 0);
        check("tmo_busy", bus_t.o_busy, 1);
        bus_t.i_req = 4'b0001;
        n = 0;
        while (!bus_t.o_gen_start && n < IFG + 10) begin
            tick();
            n++;
        end
        // IFG cycles then one IDLE cycle before the next start
        check("tmo_regrant", n, IFG + 1);
        bus_t.i_req = '0;
        for (int j = 0; j < TMO; j++) tick();
        bus_t.i_gen_done = 1'b1;
        tick();
        bus_t.i_gen_done = 1'b0;
        check("tmo_done_wins", bus_t.o_timeout, 0);
        check("tmo_done_busy", bus_t.o_busy, 1);
        $display("txn timeout: expiry then done-at-limit");

        // ---------------- randomized transactions against the model
        for (int t = 0; t < 24; t++) begin
            for (int k = 0; k < NR; k++) begin
                rlen = 16'($urandom_range(0, 70));
                set_desc(k, {16'($urandom), 32'($urandom)}, 16'($urandom), rlen);
            end
            rsrc = {16'($urandom), 32'($urandom)};
            bus.i_src_address = rsrc;
            mask = NR'($urandom_range(1, 15));
            bus.i_req = mask;
            w = rr_pick(mask, mptr);
            rlen = bus.i_payload_length[16*w +: 16];
            legal = (rlen != 0) && (rlen <= 16'(PMAX));
            tick();
            check("rnd_ack", bus.o_ack, 64'(1) << w);
            check("rnd_sel", bus.o_sel, w);
            check("rnd_start", bus.o_gen_start, legal);
            check("rnd_lerr", bus.o_len_err, !legal);
            check("rnd_dest", bus.o_dest_address, bus.i_dest_address[48*w +: 48]);
            check("rnd_type", bus.o_eth_type, bus.i_eth_type[16*w +: 16]);
            check("rnd_len", bus.o_payload_length, rlen);
            check("rnd_src", bus.o_src_address, rsrc);
            mptr = (w + 1) % NR;
            bus.i_req = '0;
            if (legal) begin
                d = $urandom_range(1, 30);
                do_done(d);
                measure_idle("rnd_idle_gap", IFG);
            end else begin
                d = 0;
                tick();
                check("rnd_lerr_idle", bus.o_busy, 0);
            end
            $display("txn rnd %0d: mask=%b src=%0d len=%0d legal=%0d done@+%0d",
                     t, mask, w, rlen, legal, d);
        end

`ifdef SCHED_STATS_EN
        // ---------------- statistics counters
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("stats_rst_frames", bus.o_frame_cnt, 0);
        check("stats_rst_err", bus.o_err_cnt, 0);
        for (int f = 0; f < 3; f++) begin
            set_desc(1, 48'h0100_0000_0001, 16'h0800, 16'd20);
            bus.i_req = 4'b0010;
            tick();
            bus.i_req = '0;
            do_done(3);
            measure_idle("stats_idle_gap", IFG);
            $display("txn stats frame %0d: src=1", f);
        end
        set_desc(1, 48'h0100_0000_0001, 16'h0800, 16'd0);
        bus.i_req = 4'b0010;
        tick();
        bus.i_req = '0;
        tick();
        check("stats_frame1", bus.o_frame_cnt[32*1 +: 32], 3);
        check("stats_frame0", bus.o_frame_cnt[32*0 +: 32], 0);
        check("stats_err", bus.o_err_cnt, 1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("stats_clr_frames", bus.o_frame_cnt, 0);
        check("stats_clr_err", bus.o_err_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
